// File: rtl/imem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory
//                responder (FSM state encoding, NOP word, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Fetch state machine encoding.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // RV32I canonical NOP (addi x0, x0, 0), returned for faulting fetches.
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    // Width of the latency down-counter (LATENCY up to 15).
    localparam int c_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder_if
//  Description : Fetch and program-load bus between a core (master) and the
//                instruction-memory responder (slave). The op_fetch_fault
//                signal exists only when IMEM_FAULT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if;

    logic [31:0] ip_instr_addr;
    logic [31:0] op_instr;
    logic        op_instr_valid;
    logic        ip_load_en;
    logic [31:0] ip_load_addr;
    logic [31:0] ip_load_data;
`ifdef IMEM_FAULT_EN
    logic        op_fetch_fault;

    modport master (
        output ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        input  op_instr, op_instr_valid, op_fetch_fault
    );
    modport slave (
        input  ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        output op_instr, op_instr_valid, op_fetch_fault
    );
`else
    modport master (
        output ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        input  op_instr, op_instr_valid
    );
    modport slave (
        input  ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        output op_instr, op_instr_valid
    );
`endif

endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_array
//  Description : DEPTH x 32 word storage, one synchronous write port and one
//                combinational read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_idx,
    input  wire logic [31:0]   i_wr_data,
    input  wire logic [AW-1:0] i_rd_idx,
    output logic      [31:0]   o_rd_data
);

    logic [31:0] r_mem [DEPTH];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Memory end of the fetch interface. Captures the requested
//                byte address, returns the addressed word LATENCY cycles
//                later with a valid strobe, and restarts the fetch whenever
//                the address changes or a load hits the word in flight.
//                Optional macro IMEM_FAULT_EN adds the op_fetch_fault output.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,        // asynchronous, active-low
    imem_responder_if.slave bus
);

    localparam int                 c_AW       = $clog2(DEPTH);
    localparam logic [31:0]        c_LIMIT    = 32'(4 * DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = (LATENCY > 1) ? c_CNT_W'(LATENCY - 2) : '0;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_req_addr, w_req_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]        r_instr, w_instr_nxt;
    logic               r_valid, w_valid_nxt;
`ifdef IMEM_FAULT_EN
    logic               r_fault, w_fault_nxt;
`endif

    logic        w_load_ok;
    logic        w_hazard;
    logic        w_capture;
    logic [31:0] w_rd_addr;
    logic        w_rd_fault;
    logic        w_fwd;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_word;

    // Loads beyond the array are dropped and never disturb a fetch.
    assign w_load_ok = bus.ip_load_en && (bus.ip_load_addr < c_LIMIT);
    // Full word-address compare: an in-range load can only hit an in-range request.
    assign w_hazard  = w_load_ok && (r_state != S_IDLE) &&
                       (bus.ip_load_addr[31:2] == r_req_addr[31:2]);
    assign w_capture = (r_state == S_IDLE) || (bus.ip_instr_addr != r_req_addr) || w_hazard;

    // On a capture edge the word comes from the incoming address (LATENCY==1 path).
    assign w_rd_addr  = w_capture ? bus.ip_instr_addr : r_req_addr;
    assign w_rd_fault = (w_rd_addr[1:0] != 2'b00) || (w_rd_addr >= c_LIMIT);
    // A load landing on the word being read this edge is forwarded, so the
    // returned value always reflects the write.
    assign w_fwd      = w_load_ok && (bus.ip_load_addr[31:2] == w_rd_addr[31:2]);
    assign w_word     = w_rd_fault ? c_NOP_INSTR :
                        (w_fwd ? bus.ip_load_data : w_mem_rdata);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_load_ok),
        .i_wr_idx  (bus.ip_load_addr[c_AW+1:2]),
        .i_wr_data (bus.ip_load_data),
        .i_rd_idx  (w_rd_addr[c_AW+1:2]),
        .o_rd_data (w_mem_rdata)
    );

    // Next-state and output computation; every target holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req_addr;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
`ifdef IMEM_FAULT_EN
        w_fault_nxt = r_fault;
`endif
        if (w_capture) begin
            w_req_nxt = bus.ip_instr_addr;
            if (LATENCY == 1) begin
                w_state_nxt = S_VALID;
                w_instr_nxt = w_word;
                w_valid_nxt = 1'b1;
`ifdef IMEM_FAULT_EN
                w_fault_nxt = w_rd_fault;
`endif
            end else begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = c_CNT_INIT;
                w_valid_nxt = 1'b0;
`ifdef IMEM_FAULT_EN
                w_fault_nxt = 1'b0;
`endif
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_VALID;
                        w_instr_nxt = w_word;
                        w_valid_nxt = 1'b1;
`ifdef IMEM_FAULT_EN
                        w_fault_nxt = w_rd_fault;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset clears everything except memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req_addr <= '0;
            r_cnt      <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
`ifdef IMEM_FAULT_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_nxt;
            r_cnt      <= w_cnt_nxt;
            r_instr    <= w_instr_nxt;
            r_valid    <= w_valid_nxt;
`ifdef IMEM_FAULT_EN
            r_fault    <= w_fault_nxt;
`endif
        end
    end

    assign bus.op_instr       = r_instr;
    assign bus.op_instr_valid = r_valid;
`ifdef IMEM_FAULT_EN
    assign bus.op_fetch_fault = r_fault;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Directed bench for imem_responder: one LATENCY=3 and one
//                LATENCY=1 instance; expected words are queued when a fetch
//                is requested and popped when the data is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
    import imem_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] q3[$];
    logic [31:0] q1[$];
    logic [31:0] mdl [5];

    imem_responder_if if3 ();
    imem_responder_if if1 ();

    imem_responder #(.DEPTH(256), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    imem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop3(input string tag);
        logic [31:0] e;
        if (q3.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q3.pop_front();
            chk({tag, "_valid"}, 32'(if3.op_instr_valid), 32'd1);
            chk(tag, if3.op_instr, e);
        end
    endtask

    task automatic pop1(input string tag);
        logic [31:0] e;
        if (q1.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q1.pop_front();
            chk({tag, "_valid"}, 32'(if1.op_instr_valid), 32'd1);
            chk(tag, if1.op_instr, e);
        end
    endtask

    initial begin
        mdl[0] = 32'hA000_0000;
        mdl[1] = 32'hA111_1111;
        mdl[2] = 32'hDEAD_BEEF;
        mdl[3] = 32'hC0FF_EE03;
        mdl[4] = 32'h4444_4444;

        rst = 1'b0;
        if3.ip_instr_addr = '0; if3.ip_load_en = 1'b0; if3.ip_load_addr = '0; if3.ip_load_data = '0;
        if1.ip_instr_addr = '0; if1.ip_load_en = 1'b0; if1.ip_load_addr = '0; if1.ip_load_data = '0;
        tick();

        // Reset state.
        chk("rst_instr3", if3.op_instr, 32'h0);
        chk("rst_valid3", 32'(if3.op_instr_valid), 32'd0);
        chk("rst_instr1", if1.op_instr, 32'h0);
        chk("rst_valid1", 32'(if1.op_instr_valid), 32'd0);
`ifdef IMEM_FAULT_EN
        chk("rst_fault3", 32'(if3.op_fetch_fault), 32'd0);
`endif

        // Preload program words (storage is independent of reset).
        for (int i = 0; i < 5; i++) begin
            if3.ip_load_en = 1'b1; if3.ip_load_addr = 32'(i * 4); if3.ip_load_data = mdl[i];
            if1.ip_load_en = 1'b1; if1.ip_load_addr = 32'(i * 4); if1.ip_load_data = mdl[i];
            tick();
        end
        if3.ip_load_en = 1'b0;
        if1.ip_load_en = 1'b0;

        // Basic fetch: L=3 at 0x8, L=1 stepping 0,4,8.
        if3.ip_instr_addr = 32'h8; q3.push_back(mdl[2]);
        if1.ip_instr_addr = 32'h0; q1.push_back(mdl[0]);
        rst = 1'b1;
        tick();
        pop1("l1_w0");
        chk("l3_wait_a", 32'(if3.op_instr_valid), 32'd0);
        if1.ip_instr_addr = 32'h4; q1.push_back(mdl[1]);
        tick();
        pop1("l1_w1");
        chk("l3_wait_b", 32'(if3.op_instr_valid), 32'd0);
        if1.ip_instr_addr = 32'h8; q1.push_back(mdl[2]);
        tick();
        pop1("l1_w2");
        pop3("l3_first");
`ifdef IMEM_FAULT_EN
        chk("l3_nofault", 32'(if3.op_fetch_fault), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("l3_hold_valid", 32'(if3.op_instr_valid), 32'd1);
            chk("l3_hold_data", if3.op_instr, mdl[2]);
        end

        // Address changes mid-wait: count restarts from second capture.
        if3.ip_instr_addr = 32'h10;
        tick();
        chk("chg_wait_a", 32'(if3.op_instr_valid), 32'd0);
        if3.ip_instr_addr = 32'hC; q3.push_back(mdl[3]);
        tick();
        chk("chg_wait_b", 32'(if3.op_instr_valid), 32'd0);
        tick();
        chk("chg_wait_c", 32'(if3.op_instr_valid), 32'd0);
        tick();
        pop3("chg_data");

        // Load hazard on the word currently valid.
        if3.ip_instr_addr = 32'h8; q3.push_back(mdl[2]);
        tick(); tick(); tick();
        pop3("back_to_8");
        mdl[2] = 32'h1234_5678;
        if3.ip_load_en = 1'b1; if3.ip_load_addr = 32'h8; if3.ip_load_data = mdl[2];
        q3.push_back(mdl[2]);
        tick();
        if3.ip_load_en = 1'b0;
        chk("haz_drop_a", 32'(if3.op_instr_valid), 32'd0);
        tick();
        chk("haz_drop_b", 32'(if3.op_instr_valid), 32'd0);
        tick();
        pop3("haz_data");

        // Out-of-range load is discarded and does not restart the fetch.
        if3.ip_load_en = 1'b1; if3.ip_load_addr = 32'h408; if3.ip_load_data = 32'hBAD0_BAD0;
        tick();
        if3.ip_load_en = 1'b0;
        chk("oob_load_valid", 32'(if3.op_instr_valid), 32'd1);
        chk("oob_load_data", if3.op_instr, 32'h1234_5678);

        // Faulting fetches: misaligned, then first address past the array.
        if3.ip_instr_addr = 32'h6; q3.push_back(c_NOP_INSTR);
        if1.ip_instr_addr = 32'h6; q1.push_back(c_NOP_INSTR);
        tick();
        pop1("l1_misalign");
        chk("mis_wait", 32'(if3.op_instr_valid), 32'd0);
        tick(); tick();
        pop3("l3_misalign");
`ifdef IMEM_FAULT_EN
        chk("mis_fault3", 32'(if3.op_fetch_fault), 32'd1);
        chk("mis_fault1", 32'(if1.op_fetch_fault), 32'd1);
`endif
        if3.ip_instr_addr = 32'h400; q3.push_back(c_NOP_INSTR);
        tick();
        chk("oob_wait", 32'(if3.op_instr_valid), 32'd0);
        tick(); tick();
        pop3("l3_oob");
`ifdef IMEM_FAULT_EN
        chk("oob_fault3", 32'(if3.op_fetch_fault), 32'd1);
`endif

        // L=1 simultaneous address change and load to the new address.
        if1.ip_instr_addr = 32'hC;
        if1.ip_load_en = 1'b1; if1.ip_load_addr = 32'hC; if1.ip_load_data = 32'h55AA_55AA;
        q1.push_back(32'h55AA_55AA);
        tick();
        if1.ip_load_en = 1'b0;
        pop1("l1_simul");

        // L=3 simultaneous address change and load to the new address.
        if3.ip_instr_addr = 32'h10;
        if3.ip_load_en = 1'b1; if3.ip_load_addr = 32'h10; if3.ip_load_data = 32'h7777_0010;
        mdl[4] = 32'h7777_0010;
        q3.push_back(mdl[4]);
        tick();
        if3.ip_load_en = 1'b0;
        chk("simul_wait", 32'(if3.op_instr_valid), 32'd0);
        tick(); tick();
        pop3("l3_simul");

        // Reset asserted mid-wait clears outputs immediately.
        if3.ip_instr_addr = 32'h4;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_instr3", if3.op_instr, 32'h0);
        chk("mid_rst_valid3", 32'(if3.op_instr_valid), 32'd0);
        chk("mid_rst_instr1", if1.op_instr, 32'h0);
        chk("mid_rst_valid1", 32'(if1.op_instr_valid), 32'd0);
        tick();
        rst = 1'b1;
        q3.push_back(mdl[1]);
        q1.push_back(32'h55AA_55AA);
        tick();
        pop1("l1_after_rst");
        chk("post_rst_a", 32'(if3.op_instr_valid), 32'd0);
        tick();
        chk("post_rst_b", 32'(if3.op_instr_valid), 32'd0);
        tick();
        pop3("l3_after_rst");

        chk("q3_drained", 32'(q3.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
